// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: programmable interval timer sequencing an n-bit up-count; TIMER_PRESCALE_EN adds a prescaler
module interval_timer_ctrl #(
  parameter int n = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               periodic,
  input  logic [n-1:0]       limit,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESC_W-1:0] prescale,
`endif
  output logic [n-1:0]       Q,
  output logic               busy,
  output logic               tick
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [n-1:0] q_q, q_d, limit_q, limit_d;
  logic tick_q, tick_d, periodic_q, periodic_d;
  logic run, launch, abort, adv, term, step;
`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  assign step = presc_q == prescale;
  always_comb presc_d = (launch || abort) ? '0 : (run && !hold) ? (step ? '0 : presc_q + 1'b1) : presc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) presc_q <= '0;
    else presc_q <= presc_d;
`else
  assign step = 1'b1;
`endif
  assign run    = state_q == RUN;
  assign launch = !run && start && !stop;
  assign abort  = run && stop;
  assign adv    = run && !stop && !hold && step;
  assign term   = adv && q_q == limit_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = launch ? RUN : (abort || (term && !periodic_q)) ? IDLE : state_q;
  always_comb begin
    q_d        = (launch || abort || term) ? '0 : adv ? q_q + 1'b1 : q_q;
    tick_d     = term;
    limit_d    = launch ? limit : limit_q;
    periodic_d = launch ? periodic : periodic_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q_q        <= '0;
      tick_q     <= 1'b0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      tick_q     <= tick_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
    end
  assign Q    = q_q;
  assign busy = run;
  assign tick = tick_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed and randomized checks of interval_timer_ctrl against a phase-count model
module tb_interval_timer_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, periodic = 1'b0;
  logic [N-1:0] limit = '0;
`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale = '0;
`endif
  logic [N-1:0] Q;
  logic busy, tick;
  int total = 0, bad = 0, ticks, cyc;
  bit cmp_en = 1'b0;
  int m_ph = 0, m_lim = 0;
  bit m_busy = 1'b0, m_tick = 1'b0, m_per = 1'b0;
  interval_timer_ctrl #(.n(N), .PRESC_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .hold(hold),
    .periodic(periodic),
    .limit(limit),
`ifdef TIMER_PRESCALE_EN
    .prescale(prescale),
`endif
    .Q(Q),
    .busy(busy),
    .tick(tick)
  );
  always #10 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  // the model counts enabled steps since start; Q and tick follow from that count modulo the period
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_tick <= 1'b0;
      m_ph   <= 0;
      m_lim  <= 0;
      m_per  <= 1'b0;
    end else if (!m_busy) begin
      m_tick <= 1'b0;
      if (start && !stop) begin
        m_busy <= 1'b1;
        m_lim  <= int'(limit);
        m_per  <= periodic;
        m_ph   <= 0;
      end
    end else if (stop) begin
      m_busy <= 1'b0;
      m_tick <= 1'b0;
    end else if (hold) m_tick <= 1'b0;
    else begin
      m_ph   <= m_ph + 1;
      m_tick <= (m_ph + 1) % (m_lim + 1) == 0;
      if ((m_ph + 1) % (m_lim + 1) == 0 && !m_per) m_busy <= 1'b0;
    end
  function automatic int m_q();
    return m_busy ? m_ph % (m_lim + 1) : 0;
  endfunction
  always @(negedge clk)
    if (cmp_en) begin
      chk("model_q", 32'(Q), 32'(m_q()));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_tick", 32'(tick), 32'(m_tick));
    end
  task automatic go(input int l, input bit p);
    @(negedge clk);
    limit = N'(l);
    periodic = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
  task automatic wait_q(input int v);
    for (int i = 0; i < 100 && Q !== N'(v); i++) @(negedge clk);
    chk("wait_q", 32'(Q), 32'(v));
  endtask
  initial begin
    #1;
    chk("rst_q", 32'(Q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;
    go(5, 0);
    chk("os_busy_k", 32'(busy), 1);
    chk("os_q_k", 32'(Q), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("os_q", 32'(Q), 32'(i));
      chk("os_notick", 32'(tick), 0);
    end
    @(negedge clk);
    chk("os_tick", 32'(tick), 1);
    chk("os_q_end", 32'(Q), 0);
    chk("os_busy_end", 32'(busy), 0);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      ticks += int'(tick);
    end
    chk("os_no_more", 32'(ticks), 0);
    go(3, 1);
    ticks = 0;
    repeat (20) begin
      @(negedge clk);
      ticks += int'(tick);
    end
    chk("per_ticks", 32'(ticks), 5);
    do_stop();
    chk("per_stopped", 32'(busy), 0);
    go(7, 1);
    @(negedge clk);
    @(negedge clk);
    chk("hold_pre", 32'(Q), 2);
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_q", 32'(Q), 2);
    end
    hold = 1'b0;
    cyc = 5;
    while (!tick && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_tick_edge", 32'(cyc), 11);
    do_stop();
    go(4, 0);
    wait_q(4);
    do_stop();
    chk("stop_tick", 32'(tick), 0);
    chk("stop_q", 32'(Q), 0);
    chk("stop_busy", 32'(busy), 0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 0);
    go(3, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("restart_q2", 32'(Q), 2);
    @(negedge clk);
    chk("restart_q3", 32'(Q), 3);
    start = 1'b0;
    do_stop();
    go(15, 1);
    limit = 4'd2;
    wait_q(14);
    @(negedge clk);
    chk("max_q15", 32'(Q), 15);
    @(negedge clk);
    chk("max_wrap_q", 32'(Q), 0);
    chk("max_wrap_tick", 32'(tick), 1);
    @(negedge clk);
    chk("max_after_wrap", 32'(Q), 1);
    do_stop();
    go(0, 1);
    repeat (4) begin
      @(negedge clk);
      chk("l0_tick", 32'(tick), 1);
      chk("l0_q", 32'(Q), 0);
    end
    do_stop();
    go(0, 0);
    @(negedge clk);
    chk("l0os_tick", 32'(tick), 1);
    chk("l0os_busy", 32'(busy), 0);
    @(negedge clk);
    chk("l0os_tick_off", 32'(tick), 0);
    go(10, 0);
    wait_q(6);
    #5 reset_n = 1'b0;
    #1;
    chk("arst_q", 32'(Q), 0);
    chk("arst_busy", 32'(busy), 0);
    #2 reset_n = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      start    = $urandom_range(0, 3) == 0;
      stop     = $urandom_range(0, 19) == 0;
      hold     = $urandom_range(0, 7) == 0;
      periodic = 1'($urandom);
      limit    = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom_range(0, 4));
    end
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
